// File: rtl/and4_seq_ctrl.sv
// Debounced push-button start controller that computes a&b&c&d from four switches
// over three FSM steps, reusing one shared 2-input AND gate for every step.
module and4_seq_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn,
  input  logic [3:0] swt,
  output logic       result,
  output logic       busy,
  output logic       done,
  output logic       ovr,
  output logic [2:0] led
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_S1   = 2'd1;
  localparam logic [1:0] ST_S2   = 2'd2;
  localparam logic [1:0] ST_S3   = 2'd3;

  logic          r_sync1;
  logic          r_sync2;
  logic          r_deb;
  logic          r_deb_d;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_state;
  logic [3:0]    r_op;
  logic          r_acc;
  logic          r_tmp;
  logic          r_result;
  logic          r_busy;
  logic          r_done;
  logic          r_ovr;

  logic          w_start;
  logic [1:0]    w_state_nxt;
  logic          w_and_a;
  logic          w_and_b;
  logic          w_and_y;

  // Synchronizer and debounce filter. The counter tracks how long the
  // synchronized button has disagreed with the accepted level.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would collapse the 2-flop chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_deb   <= 1'b0;
      r_deb_d <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= btn;
      r_sync2 <= r_sync1;
      r_deb_d <= r_deb;
      if (r_sync2 != r_deb) begin
        if (r_cnt == CNT_LAST) begin
          r_deb <= r_sync2;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  // Rising edge of the debounced level only; releases produce nothing.
  assign w_start = r_deb & ~r_deb_d;

  // Operand muxes feeding the single shared AND gate.
  // NOTE: every output of an always_comb gets a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_and_a = 1'b0;
    w_and_b = 1'b0;
    unique case (r_state)
      ST_S1:   begin w_and_a = r_op[0]; w_and_b = r_op[1]; end
      ST_S2:   begin w_and_a = r_op[2]; w_and_b = r_op[3]; end
      ST_S3:   begin w_and_a = r_acc;   w_and_b = r_tmp;   end
      default: ;
    endcase
  end

  assign w_and_y = w_and_a & w_and_b;

  always_comb begin
    w_state_nxt = ST_IDLE;
    case (r_state)
      ST_IDLE: w_state_nxt = w_start ? ST_S1 : ST_IDLE;
      ST_S1:   w_state_nxt = ST_S2;
      ST_S2:   w_state_nxt = ST_S3;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM, datapath and status flags. busy is decoded from the next state so it
  // is a clean register output aligned with the state it describes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_op     <= 4'b0000;
      r_acc    <= 1'b0;
      r_tmp    <= 1'b0;
      r_result <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ovr    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_done  <= 1'b0;
      case (r_state)
        ST_IDLE: if (w_start) r_op <= swt;
        ST_S1:   r_acc <= w_and_y;
        ST_S2:   r_tmp <= w_and_y;
        ST_S3: begin
          r_result <= w_and_y;
          r_done   <= 1'b1;
        end
        default: ;
      endcase
      if (w_start && (r_state != ST_IDLE)) r_ovr <= 1'b1;
    end
  end

  assign result = r_result;
  assign busy   = r_busy;
  assign done   = r_done;
  assign ovr    = r_ovr;
  assign led    = {r_ovr, r_busy, r_result};

endmodule

// File: tb/tb_and4_seq_ctrl.sv
// Self-checking bench for and4_seq_ctrl: directed scenarios plus random button
// and switch activity, all compared against a cycle-level behavioural model.
module tb_and4_seq_ctrl;

  localparam int N = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn   = 1'b0;
  logic [3:0] swt   = 4'b0000;
  logic       result;
  logic       busy;
  logic       done;
  logic       ovr;
  logic [2:0] led;

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;
  int edge_cnt = 0;

  // Behavioural model: debounce as "last N synchronized samples all disagree",
  // computation as a countdown whose answer is the reduction AND of the capture.
  bit m_sync1, m_sync2, m_deb, m_start_pend, m_inject;
  bit m_hist[$];
  int m_rem;
  bit m_ans, m_result, m_done, m_ovr;

  and4_seq_ctrl #(.DEBOUNCE_CYCLES(N)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn    (btn),
    .swt    (swt),
    .result (result),
    .busy   (busy),
    .done   (done),
    .ovr    (ovr),
    .led    (led)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sync1 = 0; m_sync2 = 0; m_deb = 0; m_start_pend = 0; m_inject = 0;
    m_hist.delete();
    for (int i = 0; i < N; i++) m_hist.push_back(1'b0);
    m_rem = 0; m_ans = 0; m_result = 0; m_done = 0; m_ovr = 0;
  endtask

  task automatic model_edge();
    bit start_now;
    bit all_diff;
    start_now = m_start_pend || m_inject;
    m_done = 0;
    if (m_rem > 0) begin
      if (start_now) m_ovr = 1;
      m_rem--;
      if (m_rem == 0) begin
        m_result = m_ans;
        m_done   = 1;
      end
    end else if (start_now) begin
      m_ans = &swt;
      m_rem = 3;
    end
    m_hist.push_back(m_sync2);
    void'(m_hist.pop_front());
    all_diff = 1;
    foreach (m_hist[i]) if (m_hist[i] == m_deb) all_diff = 0;
    m_start_pend = 0;
    if (all_diff) begin
      m_deb = ~m_deb;
      m_start_pend = m_deb;
    end
    m_sync2 = m_sync1;
    m_sync1 = btn;
  endtask

  function automatic logic [15:0] exp_vec();
    logic b;
    b = (m_rem > 0);
    return {9'd0, m_result, b, m_done, m_ovr, m_ovr, b, m_result};
  endfunction

  function automatic logic [15:0] dut_vec();
    return {9'd0, result, busy, done, ovr, led};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    edge_cnt++;
    check("cycle", dut_vec(), exp_vec());
    if (done === 1'b1) n_done++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic apply_reset();
    #2 rst_n = 1'b0;
    #1 model_reset();
    check("rst_vec", dut_vec(), 16'd0);
    #2 rst_n = 1'b1;
  endtask

  task automatic wait_busy(input string tag);
    bit seen;
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      tick();
      if (busy === 1'b1) seen = 1;
    end
    check(tag, 16'(seen), 16'd1);
  endtask

  initial begin
    int first_done;
    int busy_cnt;
    int len;
    model_reset();
    #1;
    check("rst_init", dut_vec(), 16'd0);
    apply_reset();

    // Clean press with all ones: latency and busy width.
    swt = 4'b1111;
    btn = 1'b1;
    edge_cnt = 0;
    first_done = 0;
    busy_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1 && first_done == 0) first_done = edge_cnt;
    end
    check("lat_edge", 16'(first_done), 16'd10);
    check("lat_busy", 16'(busy_cnt), 16'd3);
    check("t1_result", 16'(result), 16'd1);
    check("t1_led", 16'(led), 16'b001);
    btn = 1'b0;
    ticks(12);

    // Two presses with different operands; one done per press.
    n_done = 0;
    swt = 4'b1011;
    btn = 1'b1; ticks(12); btn = 1'b0; ticks(12);
    check("t2_result0", 16'(result), 16'd0);
    swt = 4'b1111;
    btn = 1'b1; ticks(12); btn = 1'b0; ticks(12);
    check("t2_result1", 16'(result), 16'd1);
    check("t2_dones", 16'(n_done), 16'd2);

    // Bouncing button: only the final stable high yields a start.
    n_done = 0;
    swt = 4'b0111;
    for (int i = 0; i < 10; i++) begin
      btn = ~btn;
      ticks(2);
    end
    btn = 1'b1; ticks(16); btn = 1'b0; ticks(12);
    check("t3_dones", 16'(n_done), 16'd1);
    check("t3_ovr", 16'(ovr), 16'd0);
    check("t3_result", 16'(result), 16'd0);

    // Switches change after capture.
    swt = 4'b1111;
    btn = 1'b1;
    wait_busy("t4_busy_seen");
    swt = 4'b0000;
    ticks(6); btn = 1'b0; ticks(12);
    check("t4_result", 16'(result), 16'd1);

    // Start while busy: injected one-cycle start pulse during S1.
    n_done = 0;
    swt = 4'b1111;
    btn = 1'b1;
    wait_busy("t5_busy_seen");
    force dut.w_start = 1'b1;
    m_inject = 1;
    tick();
    release dut.w_start;
    m_inject = 0;
    ticks(10); btn = 1'b0; ticks(12);
    check("t5_dones", 16'(n_done), 16'd1);
    check("t5_ovr", 16'(ovr), 16'd1);
    check("t5_led2", 16'(led[2]), 16'd1);
    apply_reset();
    check("t5_ovr_clr", 16'(ovr), 16'd0);

    // Reset during S2 aborts; held button restarts after release.
    swt = 4'b1111;
    btn = 1'b1;
    wait_busy("t6_busy_seen");
    tick();
    n_done = 0;
    apply_reset();
    check("t6_busy", 16'(busy), 16'd0);
    check("t6_done", 16'(done), 16'd0);
    check("t6_result", 16'(result), 16'd0);
    ticks(16);
    check("t6_restart", 16'(n_done), 16'd1);
    check("t6_result1", 16'(result), 16'd1);
    btn = 1'b0; ticks(12);

    // Random button runs and switch noise.
    for (int i = 0; i < 150; i++) begin
      btn = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 10);
      for (int j = 0; j < len; j++) begin
        swt = 4'($urandom);
        if ($urandom_range(0, 3) == 0) swt = 4'b1111;
        tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/and4_seq_ctrl.md
AND4_SEQ_CTRL -- requirements
Module: and4_seq_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, min 2: consecutive clk cycles a synchronized btn level must differ from the debounced level before the debounced level updates.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 btn  input  1  raw, asynchronous, bouncing start push-button.
REQ-005 swt  input  4  operand switches; swt[0]=a, swt[1]=b, swt[2]=c, swt[3]=d.
REQ-006 result  output  1  registered a&b&c&d of the last completed computation.
REQ-007 busy  output  1  high while a computation is in progress.
REQ-008 done  output  1  one-cycle pulse when result is updated.
REQ-009 ovr  output  1  sticky flag: a start arrived while busy.
REQ-010 led  output  3  led[0]=result, led[1]=busy, led[2]=ovr.

Function
REQ-011 btn SHALL pass through a 2-flop synchronizer (sync1, sync2) before any other use.
REQ-012 Debounce counter: increments each cycle sync2 != debounced level; clears to 0 each cycle they are equal.
REQ-013 When counter == DEBOUNCE_CYCLES-1 and sync2 still differs, the next edge loads sync2 into the debounced level and clears the counter.
REQ-014 start SHALL be an internal one-cycle pulse on the debounced 0->1 transition only; 1->0 transitions generate nothing.
REQ-015 All AND evaluation SHALL use a single shared 2-input AND; operands are selected by FSM state through operand muxes; no other AND of swt bits is allowed.
REQ-016 FSM states: IDLE, S1, S2, S3.
REQ-017 IDLE + start: capture swt into op_reg[3:0]; go to S1.
REQ-018 S1: acc <= op_reg[0] & op_reg[1]; go to S2.
REQ-019 S2: tmp <= op_reg[2] & op_reg[3]; go to S3.
REQ-020 S3: result <= acc & tmp; done <= 1 for the next cycle; go to IDLE.
REQ-021 Any other or illegal state encoding SHALL go to IDLE on the next edge.
REQ-022 busy SHALL be a registered decode, high in S1/S2/S3 and low in IDLE.
REQ-023 swt changes after capture SHALL NOT affect the current computation.
REQ-024 start while busy: computation continues unaffected; start is dropped; ovr <= 1.
REQ-025 ovr SHALL clear only on reset.
REQ-026 Between computations, result SHALL hold its value.
REQ-027 Latency: counting the first edge sampling btn high as edge 1, with no bounce, done is high after edge DEBOUNCE_CYCLES+6 for exactly one cycle.
REQ-028 A start arriving in the same cycle done is high SHALL be accepted: the FSM is in IDLE in that cycle.

Reset
REQ-029 rst_n low SHALL immediately force: FSM=IDLE, sync1=sync2=0, debounced level=0, counter=0, op_reg=acc=tmp=0, result=0, busy=0, done=0, ovr=0.
REQ-030 Reset asserted mid-computation SHALL abort it with no done pulse; the first start after rst_n rises begins a fresh computation.
REQ-031 btn held high across reset release SHALL produce a start after debouncing, because the debounced level resets to 0.

Verification (DEBOUNCE_CYCLES=4)
REQ-032 swt=4'b1111, clean btn press -> done after edge 10, result=1, led=3'b001; busy high for 3 cycles.
REQ-033 swt=4'b1011, press -> result=0; then swt=4'b1111, press -> result=1, done pulsing once per press.
REQ-034 btn toggles every 2 cycles for 20 cycles, then held high -> exactly one done; ovr stays 0.
REQ-035 swt=4'b1111, press; swt changed to 4'b0000 during S1 -> result=1.
REQ-036 Second debounced press while busy -> single done; ovr=1 and led[2]=1 until reset.
REQ-037 rst_n pulsed low during S2 -> busy=0 immediately; no done; result=0.
